// File: rtl/decoder_seq.sv
// ---------------------------------------------------------------------------
// decoder_seq
//   Registered one-hot decoder with a valid/ready command interface.
//   An accepted command drives dec_out = 1 << sel in one of three modes:
//     LEVEL   - held until replaced by another command
//     PULSE   - high for exactly one cycle
//     STRETCH - high for PULSE_LEN cycles (no commands taken meanwhile)
//   Mode 11 is reserved: it is counted but only raises a one-cycle err.
//   A wrapping counter tracks every accepted command.
//
// Ports
//   clk       in   1            rising-edge clock
//   rst_n     in   1            asynchronous active-low reset
//   enable    in   1            low: output forced inactive, no accepts
//   in_valid  in   1            command valid
//   in_ready  out  1            command can be accepted this cycle
//   sel       in   IN_W         channel select
//   mode      in   2            00 LEVEL, 01 PULSE, 10 STRETCH, 11 reserved
//   dec_out   out  2**IN_W      registered one-hot output, zero when inactive
//   idle      out  1            FSM idle and output zero
//   err       out  1            one-cycle pulse after accepting mode 11
//   acc_cnt   out  CNT_W        accepted-command count (wraps)
// ---------------------------------------------------------------------------
module decoder_seq #(
    parameter int IN_W      = 3,
    parameter int PULSE_LEN = 4,   // legal range 1..255
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_W-1:0]      sel,
    input  logic [1:0]           mode,
    output logic [2**IN_W-1:0]   dec_out,
    output logic                 idle,
    output logic                 err,
    output logic [CNT_W-1:0]     acc_cnt
);

    localparam int OUT_W = 2**IN_W;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LEVEL   = 2'd1,
        S_PULSE   = 2'd2,
        S_STRETCH = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        M_LEVEL   = 2'b00,
        M_PULSE   = 2'b01,
        M_STRETCH = 2'b10,
        M_RSVD    = 2'b11
    } mode_e;

    state_e             state_q;
    logic [OUT_W-1:0]   dec_q;
    logic [7:0]         cnt_q;     // remaining STRETCH cycles after the current one
    logic               err_q;
    logic [CNT_W-1:0]   acc_q;

    logic [OUT_W-1:0]   onehot_d;
    logic               accept;

    // Only the state is consulted, never in_valid, so ready does not
    // depend combinationally on the command it gates.
    assign in_ready = enable && (state_q != S_STRETCH);
    assign accept   = in_valid && in_ready;
    assign onehot_d = OUT_W'(1) << sel;

    // NOTE: every register is assigned with <= so all state updates see the
    // pre-edge values; mixing in = here would create order-dependent logic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            dec_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            acc_q   <= '0;
        end else if (!enable) begin
            // Disable wins over everything except the counter, which holds.
            state_q <= S_IDLE;
            dec_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (accept) begin
                // Same transitions from IDLE, LEVEL and PULSE; STRETCH never
                // reaches here because in_ready is low in that state.
                acc_q <= acc_q + CNT_W'(1);
                case (mode_e'(mode))
                    M_LEVEL: begin
                        state_q <= S_LEVEL;
                        dec_q   <= onehot_d;
                    end
                    M_PULSE: begin
                        state_q <= S_PULSE;
                        dec_q   <= onehot_d;
                    end
                    M_STRETCH: begin
                        state_q <= S_STRETCH;
                        dec_q   <= onehot_d;
                        cnt_q   <= 8'(PULSE_LEN - 1);
                    end
                    M_RSVD: begin
                        state_q <= S_IDLE;
                        dec_q   <= '0;
                        err_q   <= 1'b1;
                    end
                endcase
            end else begin
                case (state_q)
                    S_IDLE:  dec_q <= '0;
                    S_LEVEL: ;  // hold output
                    S_PULSE: begin
                        state_q <= S_IDLE;
                        dec_q   <= '0;
                    end
                    S_STRETCH: begin
                        if (cnt_q == 8'd0) begin
                            state_q <= S_IDLE;
                            dec_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q - 8'd1;
                        end
                    end
                endcase
            end
        end
    end

    assign dec_out = dec_q;
    assign err     = err_q;
    assign acc_cnt = acc_q;
    assign idle    = (state_q == S_IDLE) && (dec_q == '0);

endmodule

// File: tb/tb_decoder_seq.sv
// ---------------------------------------------------------------------------
// tb_decoder_seq
//   Directed bench for decoder_seq (IN_W=3, PULSE_LEN=4, CNT_W=8).
//   A table of single-cycle vectors covers LEVEL/PULSE/reserved behaviour;
//   hand-written sequences cover reset, STRETCH with held valid, enable drop
//   mid-STRETCH, counter wrap and async reset during STRETCH.
// ---------------------------------------------------------------------------
module tb_decoder_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] sel;
    logic [1:0] mode;
    logic [7:0] dec_out;
    logic       idle;
    logic       err;
    logic [7:0] acc_cnt;

    int checks = 0;
    int errors = 0;

    decoder_seq #(.IN_W(3), .PULSE_LEN(4), .CNT_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .sel      (sel),
        .mode     (mode),
        .dec_out  (dec_out),
        .idle     (idle),
        .err      (err),
        .acc_cnt  (acc_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       vld;
        logic [2:0] sel;
        logic [1:0] mode;
        logic [7:0] dec;
        logic       rdy;
        logic       idl;
        logic       er;
        logic [7:0] acc;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input logic [7:0] d, input logic r,
                              input logic i, input logic e, input logic [7:0] a);
        check({tag, ".dec_out"},  32'(dec_out),  32'(d));
        check({tag, ".in_ready"}, 32'(in_ready), 32'(r));
        check({tag, ".idle"},     32'(idle),     32'(i));
        check({tag, ".err"},      32'(err),      32'(e));
        check({tag, ".acc_cnt"},  32'(acc_cnt),  32'(a));
    endtask

    // Advance one rising edge and sample 1 ns later; also check one-hot-or-zero.
    task automatic tick();
        @(posedge clk);
        #1;
        check("onehot", 32'($countones(dec_out) <= 1), 32'd1);
    endtask

    initial begin
        // ---------------- table ----------------
        //             en  vld sel   mode   dec    rdy  idl  er   acc
        vecs[0]  = '{1'b1,1'b1,3'd5,2'b00,8'h20,1'b1,1'b0,1'b0,8'd1};   // LEVEL sel5
        vecs[1]  = '{1'b1,1'b0,3'd0,2'b00,8'h20,1'b1,1'b0,1'b0,8'd1};
        vecs[2]  = '{1'b1,1'b0,3'd0,2'b00,8'h20,1'b1,1'b0,1'b0,8'd1};
        vecs[3]  = '{1'b1,1'b1,3'd2,2'b01,8'h04,1'b1,1'b0,1'b0,8'd2};   // PULSE sel2
        vecs[4]  = '{1'b1,1'b0,3'd0,2'b00,8'h00,1'b1,1'b1,1'b0,8'd2};
        vecs[5]  = '{1'b1,1'b1,3'd0,2'b01,8'h01,1'b1,1'b0,1'b0,8'd3};   // b2b PULSE
        vecs[6]  = '{1'b1,1'b1,3'd1,2'b01,8'h02,1'b1,1'b0,1'b0,8'd4};
        vecs[7]  = '{1'b1,1'b1,3'd2,2'b01,8'h04,1'b1,1'b0,1'b0,8'd5};
        vecs[8]  = '{1'b1,1'b1,3'd3,2'b01,8'h08,1'b1,1'b0,1'b0,8'd6};
        vecs[9]  = '{1'b1,1'b0,3'd0,2'b00,8'h00,1'b1,1'b1,1'b0,8'd6};
        vecs[10] = '{1'b1,1'b1,3'd3,2'b11,8'h00,1'b1,1'b1,1'b1,8'd7};   // reserved
        vecs[11] = '{1'b1,1'b0,3'd0,2'b00,8'h00,1'b1,1'b1,1'b0,8'd7};
        vecs[12] = '{1'b1,1'b1,3'd6,2'b00,8'h40,1'b1,1'b0,1'b0,8'd8};   // LEVEL sel6
        vecs[13] = '{1'b1,1'b1,3'd6,2'b11,8'h00,1'b1,1'b1,1'b1,8'd9};   // reserved from LEVEL
        vecs[14] = '{1'b1,1'b0,3'd0,2'b00,8'h00,1'b1,1'b1,1'b0,8'd9};
        vecs[15] = '{1'b0,1'b1,3'd1,2'b00,8'h00,1'b0,1'b1,1'b0,8'd9};   // disabled: no accept
        vecs[16] = '{1'b1,1'b0,3'd0,2'b00,8'h00,1'b1,1'b1,1'b0,8'd9};
        vecs[17] = '{1'b1,1'b1,3'd1,2'b00,8'h02,1'b1,1'b0,1'b0,8'd10};  // LEVEL replaced
        vecs[18] = '{1'b1,1'b1,3'd4,2'b00,8'h10,1'b1,1'b0,1'b0,8'd11};
        vecs[19] = '{1'b1,1'b0,3'd0,2'b00,8'h10,1'b1,1'b0,1'b0,8'd11};

        // ---------------- reset ----------------
        rst_n = 1'b0; enable = 1'b1; in_valid = 1'b0; sel = '0; mode = '0;
        #12 rst_n = 1'b1;
        in_valid = 1'b1; sel = 3'd1; mode = 2'b00;
        tick();
        check("pre_reset.dec_out", 32'(dec_out), 32'h02);
        in_valid = 1'b0;
        #3 rst_n = 1'b0;            // mid-cycle, no clock edge involved
        #1 check_outs("reset", 8'h00, 1'b1, 1'b1, 1'b0, 8'd0);
        #2 rst_n = 1'b1;

        // ---------------- table vectors ----------------
        for (int i = 0; i < NV; i++) begin
            enable = vecs[i].en; in_valid = vecs[i].vld;
            sel    = vecs[i].sel; mode    = vecs[i].mode;
            tick();
            check_outs($sformatf("vec%0d", i), vecs[i].dec, vecs[i].rdy,
                       vecs[i].idl, vecs[i].er, vecs[i].acc);
        end

        // ---------------- STRETCH with in_valid held ----------------
        in_valid = 1'b1; sel = 3'd7; mode = 2'b10;
        for (int c = 0; c < 4; c++) begin
            tick();
            check_outs($sformatf("stretch_c%0d", c), 8'h80, 1'b0, 1'b0, 1'b0, 8'd12);
        end
        tick();   // held valid ignored while busy: not queued
        check_outs("stretch_end", 8'h00, 1'b1, 1'b1, 1'b0, 8'd12);
        tick();   // next accept one cycle later
        check_outs("stretch2_c0", 8'h80, 1'b0, 1'b0, 1'b0, 8'd13);

        // ---------------- enable drop on 2nd STRETCH cycle ----------------
        in_valid = 1'b0;
        tick();
        check_outs("stretch2_c1", 8'h80, 1'b0, 1'b0, 1'b0, 8'd13);
        enable = 1'b0;
        tick();
        check_outs("disable", 8'h00, 1'b0, 1'b1, 1'b0, 8'd13);
        enable = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            check_outs($sformatf("reenable%0d", c), 8'h00, 1'b1, 1'b1, 1'b0, 8'd13);
        end
        in_valid = 1'b1; sel = 3'd0; mode = 2'b01;
        tick();
        check_outs("post_reenable", 8'h01, 1'b1, 1'b0, 1'b0, 8'd14);

        // ---------------- counter wrap: 256 LEVEL accepts ----------------
        mode = 2'b00;
        for (int n = 0; n < 256; n++) begin
            sel = 3'(n);
            tick();
            check("wrap.dec_out", 32'(dec_out), 32'(8'h01 << (n % 8)));
            if (n == 241) check("wrap.zero", 32'(acc_cnt), 32'd0);
        end
        check("wrap.final", 32'(acc_cnt), 32'd14);

        // ---------------- async reset mid-STRETCH ----------------
        sel = 3'd3; mode = 2'b10;
        tick();
        in_valid = 1'b0;
        check("rst_stretch.pre", 32'(dec_out), 32'h08);
        tick();
        #3 rst_n = 1'b0;
        #1 check_outs("rst_stretch", 8'h00, 1'b1, 1'b1, 1'b0, 8'd0);
        #2 rst_n = 1'b1;
        tick();
        check_outs("after_rst", 8'h00, 1'b1, 1'b1, 1'b0, 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
